// File: rtl/sect163r1_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sect163r1_pkg : GF(2^163) constants, element type and squarer helper.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sect163r1_pkg;

    localparam int M = 163;

    typedef logic [M-1:0] gf_t;

    // f(t) = t^163 + t^7 + t^6 + t^3 + 1, implicit top term dropped
    localparam gf_t POLY = 163'hC9;

    // Multiply by t, folding t^163 back into the low terms.
    function automatic gf_t gf_mulx(input gf_t a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
    endfunction

    // Square: spread bits to even positions, then reduce from the top down so
    // any folded bits landing above t^162 are caught by later iterations.
    function automatic gf_t gf_sqr(input gf_t a);
        logic [2*M-2:0] w;
        w = '0;
        for (int i = 0; i < M; i++) begin
            w[2*i] = a[i];
        end
        for (int i = 2*M-2; i >= M; i--) begin
            if (w[i]) begin
                w[i-M +: 8] ^= POLY[7:0];
            end
        end
        return w[M-1:0];
    endfunction

    // Squarings per Itoh-Tsujii step for the addition chain 1,2,4,...,160,162.
    function automatic logic [6:0] it_len(input logic [3:0] s);
        case (s)
            4'd0:    return 7'd1;
            4'd1:    return 7'd2;
            4'd2:    return 7'd4;
            4'd3:    return 7'd8;
            4'd4:    return 7'd16;
            4'd5:    return 7'd32;
            4'd6:    return 7'd64;
            4'd7:    return 7'd32;
            default: return 7'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sect163r1_gf_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sect163r1_gf_mul : MSB-first digit-serial GF(2^163) multiplier.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sect163r1_gf_mul
    import sect163r1_pkg::*;
#(
    parameter int MulDigit = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic start,
    input  gf_t  a,
    input  gf_t  b,
    output logic busy,
    output logic done,
    output gf_t  p
);

    localparam int NM = (M + MulDigit - 1) / MulDigit;
    localparam int PW = NM * MulDigit;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NM - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam bit SINGLE = (NM == 1);

    logic                launch;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       cur_idx;
    logic [PW-1:0]       b_pad;
    logic [MulDigit-1:0] dig;
    gf_t                 acc_in;
    gf_t                 acc_nx;

    // Operands must stay stable for the whole operation; the first digit is
    // consumed on the launch edge so a multiply takes exactly NM edges.
    assign launch  = start && !busy;
    assign cur_idx = launch ? LAST_IDX : idx;
    assign b_pad   = PW'(b);
    assign dig     = MulDigit'(b_pad >> (int'(cur_idx) * MulDigit));
    assign acc_in  = launch ? '0 : p;
    assign done    = (launch && SINGLE) || (busy && (idx == '0));

    always_comb begin
        acc_nx = acc_in;
        for (int i = MulDigit - 1; i >= 0; i--) begin
            acc_nx = gf_mulx(acc_nx);
            if (dig[i]) begin
                acc_nx = acc_nx ^ a;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p    <= '0;
            busy <= 1'b0;
            idx  <= '0;
        end else if (clr) begin
            p    <= '0;
            busy <= 1'b0;
            idx  <= '0;
        end else if (launch) begin
            p    <= acc_nx;
            busy <= !SINGLE;
            idx  <= LAST_IDX - IDX_ONE;
        end else if (busy) begin
            p <= acc_nx;
            if (idx == '0) begin
                busy <= 1'b0;
            end else begin
                idx <= idx - IDX_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sect163r1_pt_compress.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sect163r1_pt_compress : SEC1 point compression, ybit = lsb(y * x^-1).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sect163r1_pt_compress
    import sect163r1_pkg::*;
#(
    parameter int MulDigit = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         start,
    input  logic [M-1:0] x_in,
    input  logic [M-1:0] y_in,
    output logic         busy,
    output logic         done,
    output logic         ybit,
    output logic [175:0] pc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ITSQ  = 3'd2;
    localparam logic [2:0] S_ITMUL = 3'd3;
    localparam logic [2:0] S_FSQ   = 3'd4;
    localparam logic [2:0] S_ZMUL  = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    localparam logic [3:0] LAST_STEP = 4'd8;

    logic [2:0] state;
    gf_t        x_r;
    gf_t        y_r;
    gf_t        beta;
    gf_t        opnd;
    gf_t        b2;
    gf_t        b32;
    logic [3:0] step;
    logic [6:0] sq_cnt;
    logic       fresh;

    gf_t  src;
    gf_t  sq_out;
    gf_t  mul_a;
    gf_t  mul_b;
    gf_t  mul_p;
    logic mul_go;
    logic mul_busy;
    logic mul_done;

    // fresh marks that the latest product sits in mul_p and not yet in beta.
    assign src    = fresh ? mul_p : beta;
    assign sq_out = gf_sqr(src);
    assign mul_a  = (state == S_ZMUL) ? y_r  : beta;
    assign mul_b  = (state == S_ZMUL) ? beta : opnd;
    assign mul_go = ((state == S_ITMUL) || ((state == S_ZMUL) && !fresh)) && !mul_busy;
    assign busy   = (state != S_IDLE) && (state != S_OUT);

    sect163r1_gf_mul #(
        .MulDigit (MulDigit)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .start (mul_go),
        .a     (mul_a),
        .b     (mul_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            x_r    <= '0;
            y_r    <= '0;
            beta   <= '0;
            opnd   <= '0;
            b2     <= '0;
            b32    <= '0;
            step   <= '0;
            sq_cnt <= '0;
            fresh  <= 1'b0;
            done   <= 1'b0;
            ybit   <= 1'b0;
            pc     <= '0;
        end else if (clr) begin
            state  <= S_IDLE;
            x_r    <= '0;
            y_r    <= '0;
            beta   <= '0;
            opnd   <= '0;
            b2     <= '0;
            b32    <= '0;
            step   <= '0;
            sq_cnt <= '0;
            fresh  <= 1'b0;
            done   <= 1'b0;
            ybit   <= 1'b0;
            pc     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    beta   <= x_r;
                    step   <= '0;
                    sq_cnt <= '0;
                    fresh  <= 1'b0;
                    state  <= S_ITSQ;
                end
                S_ITSQ: begin
                    beta  <= sq_out;
                    fresh <= 1'b0;
                    // At step entry src is beta_k: doubling steps multiply by it,
                    // the last two steps reuse the banked beta_32 and beta_2.
                    if (sq_cnt == '0) begin
                        case (step)
                            4'd7:    opnd <= b32;
                            4'd8:    opnd <= b2;
                            default: opnd <= src;
                        endcase
                        if (step == 4'd1) b2  <= src;
                        if (step == 4'd5) b32 <= src;
                    end
                    if (sq_cnt == (it_len(step) - 7'd1)) begin
                        sq_cnt <= '0;
                        state  <= S_ITMUL;
                    end else begin
                        sq_cnt <= sq_cnt + 7'd1;
                    end
                end
                S_ITMUL: begin
                    if (mul_done) begin
                        fresh <= 1'b1;
                        if (step == LAST_STEP) begin
                            state <= S_FSQ;
                        end else begin
                            step  <= step + 4'd1;
                            state <= S_ITSQ;
                        end
                    end
                end
                S_FSQ: begin
                    beta  <= sq_out;
                    fresh <= 1'b0;
                    state <= S_ZMUL;
                end
                S_ZMUL: begin
                    if (fresh) begin
                        ybit  <= mul_p[0];
                        pc    <= {7'b0000001, mul_p[0], 5'b00000, x_r};
                        done  <= 1'b1;
                        fresh <= 1'b0;
                        state <= S_OUT;
                    end else if (mul_done) begin
                        fresh <= 1'b1;
                    end
                end
                S_OUT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sect163r1_pt_compress.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sect163r1_pt_compress : directed + random checks against a GF model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sect163r1_pt_compress;

    localparam int MUL_DIGIT = 1;
    localparam int NM        = (163 + MUL_DIGIT - 1) / MUL_DIGIT;
    localparam int LAT       = 2 + 162 + 10 * NM;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         clr   = 1'b0;
    logic         start = 1'b0;
    logic [162:0] x_in  = '0;
    logic [162:0] y_in  = '0;
    logic         busy;
    logic         done;
    logic         ybit;
    logic [175:0] pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sect163r1_pt_compress #(
        .MulDigit (MUL_DIGIT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .ybit  (ybit),
        .pc    (pc)
    );

    // Schoolbook polynomial product followed by long-division reduction.
    function automatic logic [162:0] m_mul(input logic [162:0] a, input logic [162:0] b);
        logic [325:0] prod;
        logic [325:0] f;
        prod = '0;
        for (int i = 0; i < 163; i++) begin
            if (b[i]) prod ^= ({163'b0, a} << i);
        end
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        for (int i = 325; i >= 163; i--) begin
            if (prod[i]) prod ^= (f << (i - 163));
        end
        return prod[162:0];
    endfunction

    // Fermat inverse: x^(2^163-2) = product of x^(2^i) for i = 1..162.
    function automatic logic [162:0] m_inv(input logic [162:0] a);
        logic [162:0] s;
        logic [162:0] r;
        s = a;
        r = 163'd1;
        for (int i = 1; i < 163; i++) begin
            s = m_mul(s, s);
            r = m_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic m_ybit(input logic [162:0] x, input logic [162:0] y);
        logic [162:0] z;
        z = m_mul(y, m_inv(x));
        return z[0];
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[162:0];
    endfunction

    task automatic chk(input string tag, input logic [175:0] obs, input logic [175:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [162:0] x, input logic [162:0] y);
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [162:0] x, input logic [162:0] y);
        int           cyc;
        bit           got;
        logic         yb;
        logic [175:0] epc;
        yb  = m_ybit(x, y);
        epc = {7'b0000001, yb, 5'b00000, x};
        launch(x, y);
        @(posedge clk);
        #1;
        chk({tag, " busy"}, 176'(busy), 176'(1'b1));
        wait_done(LAT + 20, cyc, got);
        chk({tag, " latency"}, 176'(got ? cyc + 1 : 0), 176'(LAT));
        chk({tag, " ybit"}, 176'(ybit), 176'(yb));
        chk({tag, " pc"}, pc, epc);
        chk({tag, " busy@done"}, 176'(busy), 176'(1'b0));
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, 176'(done), 176'(1'b0));
    endtask

    initial begin
        logic [162:0] gx;
        logic [162:0] gy;
        logic [162:0] x1;
        logic [162:0] y1;
        logic [175:0] e;
        logic         yb;
        int           cyc;
        bit           got;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 176'(busy), 176'(1'b0));
        chk("reset done", 176'(done), 176'(1'b0));
        chk("reset ybit", 176'(ybit), 176'(1'b0));
        chk("reset pc", pc, 176'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op("x1y1", 163'd1, 163'd1);
        chk("x1y1 ybit const", 176'(ybit), 176'(1'b1));
        chk("x1y1 octet", 176'(pc[175:168]), 176'(8'h03));
        chk("x1y1 xfield", 176'(pc[162:0]), 176'(1));

        run_op("x2y1", 163'd2, 163'd1);
        chk("x2y1 ybit const", 176'(ybit), 176'(1'b0));
        chk("x2y1 octet", 176'(pc[175:168]), 176'(8'h02));

        run_op("x2y2", 163'd2, 163'd2);
        chk("x2y2 ybit const", 176'(ybit), 176'(1'b1));

        run_op("x0y5", 163'd0, 163'd5);
        e = '0;
        e[169] = 1'b1;
        chk("x0y5 pc const", pc, e);

        gx = 163'h0369979697AB43897789566789567F787A7876A654;
        gy = 163'h00435EDB42EFAFB2989D51FEFCE3C80988F41FF883;
        run_op("gen", gx, gy);

        for (int k = 0; k < 8; k++) begin
            run_op($sformatf("rnd%0d", k), rnd163(), rnd163());
        end

        // second start at cycle 500 must be ignored
        x1 = rnd163();
        y1 = rnd163();
        yb = m_ybit(x1, y1);
        launch(x1, y1);
        repeat (498) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        x_in  = ~x1;
        y_in  = ~y1;
        @(negedge clk);
        start = 1'b0;
        wait_done(LAT + 20, cyc, got);
        chk("restart latency", 176'(got ? cyc + 499 : 0), 176'(LAT));
        chk("restart ybit", 176'(ybit), 176'(yb));
        chk("restart pc", pc, {7'b0000001, yb, 5'b00000, x1});
        wait_done(LAT + 20, cyc, got);
        chk("restart no 2nd done", 176'(got), 176'(1'b0));

        // synchronous clear at cycle 700
        launch(rnd163(), rnd163());
        repeat (698) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr busy", 176'(busy), 176'(1'b0));
        chk("clr done", 176'(done), 176'(1'b0));
        chk("clr ybit", 176'(ybit), 176'(1'b0));
        chk("clr pc", pc, 176'(0));
        wait_done(LAT + 20, cyc, got);
        chk("clr no done", 176'(got), 176'(1'b0));
        run_op("post clr", 163'd1, 163'd1);
        chk("post clr ybit const", 176'(ybit), 176'(1'b1));

        // asynchronous reset mid-cycle
        launch(rnd163(), rnd163());
        repeat (300) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst busy", 176'(busy), 176'(1'b0));
        chk("rst done", 176'(done), 176'(1'b0));
        chk("rst ybit", 176'(ybit), 176'(1'b0));
        chk("rst pc", pc, 176'(0));
        @(negedge clk);
        rst = 1'b0;
        wait_done(LAT + 20, cyc, got);
        chk("rst no done", 176'(got), 176'(1'b0));
        run_op("post rst", 163'd1, 163'd1);
        chk("post rst ybit const", 176'(ybit), 176'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
